// File: rtl/pp_pipeline_accel_line_buffer_fill_n.sv
// Streams FIFO pixels into a rotating set of NUM_LINES line buffers, one pixel per cycle.
// Define LB_FILL_REPLICATE_EN to append a right-edge replicate write after each row.
module pp_pipeline_accel_line_buffer_fill_n #(
  parameter  int PIX_W     = 24,
  parameter  int NUM_LINES = 3,
  parameter  int ADDR_W    = 12,
  parameter  int ROW_W     = 16,
  localparam int LSEL_W    = $clog2(NUM_LINES)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_ready,
  input  logic [ROW_W-1:0]     num_rows,
  input  logic [ADDR_W-1:0]    row_width,
  input  logic [LSEL_W-1:0]    first_line,
  output logic [LSEL_W-1:0]    next_line,
  input  logic [PIX_W-1:0]     src_dout,
  input  logic                 src_empty_n,
  output logic                 src_read,
  output logic [ADDR_W-1:0]    lb_address0,
  output logic [PIX_W-1:0]     lb_d0,
  output logic [NUM_LINES-1:0] lb_ce0,
  output logic [NUM_LINES-1:0] lb_we0
);

  typedef enum logic [0:0] {
    S_IDLE,
    S_FILL
  } state_t;

  localparam logic [LSEL_W-1:0] LAST_LINE = LSEL_W'(NUM_LINES - 1);

  state_t state, state_nx;

  logic [ROW_W-1:0]  rows_q, row_q;
  logic [ADDR_W-1:0] width_q, col_q;
  logic [LSEL_W-1:0] line_q;
  logic              degen_q;
  logic              rep_q;

  logic              wr_valid, wr_last;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [LSEL_W-1:0] wr_line;

  logic start_ok, pop, col_end, row_end, fin;

  always_comb begin
    start_ok = (state == S_IDLE) && !wr_valid && ap_start;
    pop      = (state == S_FILL) && !degen_q && src_empty_n && !rep_q;
    col_end  = (col_q == width_q - ADDR_W'(1));
    row_end  = (row_q == rows_q - ROW_W'(1));
`ifdef LB_FILL_REPLICATE_EN
    fin = (state == S_FILL) && (degen_q || (rep_q && row_q == rows_q));
`else
    fin = (state == S_FILL) && (degen_q || (pop && col_end && row_end));
`endif
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nx = S_FILL;
      S_FILL:  if (fin) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      rows_q    <= '0;
      row_q     <= '0;
      width_q   <= '0;
      col_q     <= '0;
      line_q    <= '0;
      degen_q   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_last   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_line   <= '0;
      next_line <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        rows_q  <= num_rows;
        width_q <= row_width;
        line_q  <= first_line;
        row_q   <= '0;
        col_q   <= '0;
        degen_q <= (num_rows == '0) || (row_width == '0);
      end else if (pop) begin
        col_q <= col_end ? '0 : col_q + ADDR_W'(1);
        if (col_end) begin
          row_q  <= row_q + ROW_W'(1);
          line_q <= (line_q == LAST_LINE) ? '0 : line_q + LSEL_W'(1);
        end
      end
      // write stage: capture on pop, or re-emit last pixel at address row_width
      if (pop) begin
        wr_valid <= 1'b1;
        wr_data  <= src_dout;
        wr_addr  <= col_q;
        wr_line  <= line_q;
`ifdef LB_FILL_REPLICATE_EN
        wr_last  <= 1'b0;
`else
        wr_last  <= col_end && row_end;
`endif
      end else if (state == S_FILL && rep_q) begin
        wr_valid <= 1'b1;
        wr_addr  <= width_q;
        wr_last  <= (row_q == rows_q);
      end else begin
        wr_valid <= 1'b0;
        wr_last  <= 1'b0;
      end
      if (ap_done) next_line <= line_q;
    end
  end

`ifdef LB_FILL_REPLICATE_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rep_q <= 1'b0;
    end else if (start_ok) begin
      rep_q <= 1'b0;
    end else if (pop) begin
      rep_q <= col_end;
    end else if (state == S_FILL) begin
      rep_q <= 1'b0;
    end
  end
`else
  assign rep_q = 1'b0;
`endif

  always_comb begin
    ap_done     = (wr_valid && wr_last) || (state == S_FILL && degen_q);
    ap_ready    = ap_done;
    ap_idle     = (state == S_IDLE) && !wr_valid;
    src_read    = pop;
    lb_address0 = wr_addr;
    lb_d0       = wr_data;
    lb_ce0      = wr_valid ? (NUM_LINES'(1) << wr_line) : '0;
    lb_we0      = lb_ce0;
  end

endmodule

// File: tb/tb_pp_pipeline_accel_line_buffer_fill_n.sv
// Randomized bench for the line-buffer fill block against a per-pixel
// placement model (row = k / width, line = (first + row) % NUM_LINES).
module tb_pp_pipeline_accel_line_buffer_fill_n;

  localparam int PIX_W     = 24;
  localparam int NUM_LINES = 3;
  localparam int LSEL_W    = $clog2(NUM_LINES);
  localparam int ADDR_W    = 12;
  localparam int ROW_W     = 16;
`ifdef LB_FILL_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic                 ap_clk = 1'b0;
  logic                 ap_rst;
  logic                 ap_start;
  logic                 ap_done, ap_idle, ap_ready;
  logic [ROW_W-1:0]     num_rows;
  logic [ADDR_W-1:0]    row_width;
  logic [LSEL_W-1:0]    first_line;
  logic [LSEL_W-1:0]    next_line;
  logic [PIX_W-1:0]     src_dout;
  logic                 src_empty_n;
  logic                 src_read;
  logic [ADDR_W-1:0]    lb_address0;
  logic [PIX_W-1:0]     lb_d0;
  logic [NUM_LINES-1:0] lb_ce0, lb_we0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int             line;
    int             addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  wr_t              q[$];
  logic [PIX_W-1:0] pix[$];

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_line_buffer_fill_n #(
    .PIX_W(PIX_W), .NUM_LINES(NUM_LINES), .ADDR_W(ADDR_W), .ROW_W(ROW_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .num_rows(num_rows), .row_width(row_width),
    .first_line(first_line), .next_line(next_line),
    .src_dout(src_dout), .src_empty_n(src_empty_n), .src_read(src_read),
    .lb_address0(lb_address0), .lb_d0(lb_d0),
    .lb_ce0(lb_ce0), .lb_we0(lb_we0)
  );

  // One complete run; called in cycle 0 (just after a posedge), returns
  // one cycle after ap_done, so back-to-back calls start with no gap.
  task automatic run(input int rows, input int width, input int first,
                     input int stall_pct, input int stall_at,
                     input int stall_len, input bit seq_pix,
                     input int exp_dc);
    int P = rows * width;
    int popped = 0, stalls = 0, forced = 0, done_cyc = -1, cyc;
    int exp_cyc, exp_nl;
    bit rep_slot = 0, pend = 0, pend_nx, empty, exp_rd, exp_done, seen;
    logic [NUM_LINES-1:0] exp_we;
    q.delete();
    pix.delete();
    for (int k = 0; k < P; k++) begin
      wr_t w;
      pix.push_back(seq_pix ? PIX_W'(k) : PIX_W'($urandom));
      w.line = (first + k / width) % NUM_LINES;
      w.addr = k % width;
      w.data = pix[k];
      q.push_back(w);
      if (REP && (k % width == width - 1)) begin
        w.addr = width;
        q.push_back(w);
      end
    end
    ap_start = 1'b1;
    num_rows = ROW_W'(rows);
    row_width = ADDR_W'(width);
    first_line = LSEL_W'(first);
    src_empty_n = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_at_start: got %b want 1", ap_idle);
    end
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    num_rows = ROW_W'($urandom);
    row_width = ADDR_W'($urandom);
    first_line = LSEL_W'($urandom % NUM_LINES);
    seen = 0;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      ap_start = 1'($urandom % 2);
      if (popped == stall_at && forced < stall_len) begin
        empty = 1;
        forced++;
      end else begin
        empty = ($urandom % 100) < stall_pct;
      end
      src_empty_n = !empty;
      src_dout = (!empty && popped < P) ? pix[popped] : PIX_W'($urandom);
      exp_rd = (popped < P) && !empty && !rep_slot;
      if (popped < P && empty && !rep_slot) stalls++;
      @(negedge ap_clk);
      checks++;
      if (src_read !== exp_rd) begin
        errors++;
        $display("FAIL src_read c%0d: got %b want %b", cyc, src_read, exp_rd);
      end
      checks++;
      if (ap_idle !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy c%0d: got %b want 0", cyc, ap_idle);
      end
      checks++;
      if (pend && q.size() > 0) begin
        exp_we = '0;
        exp_we[q[0].line] = 1'b1;
        if (lb_we0 !== exp_we || lb_ce0 !== exp_we ||
            lb_address0 !== ADDR_W'(q[0].addr) || lb_d0 !== q[0].data) begin
          errors++;
          $display("FAIL write c%0d: got we=%b ce=%b a=%0d d=%h want we=%b a=%0d d=%h",
                   cyc, lb_we0, lb_ce0, lb_address0, lb_d0,
                   exp_we, q[0].addr, q[0].data);
        end
        void'(q.pop_front());
      end else if (pend || lb_we0 !== '0 || lb_ce0 !== '0) begin
        errors++;
        $display("FAIL no_write c%0d: got we=%b ce=%b want 0", cyc, lb_we0, lb_ce0);
      end
      exp_done = (pend && q.size() == 0) || (P == 0 && cyc == 1);
      checks++;
      if (ap_done !== exp_done || ap_ready !== exp_done) begin
        errors++;
        $display("FAIL done c%0d: got done=%b ready=%b want %b",
                 cyc, ap_done, ap_ready, exp_done);
      end
      pend_nx = exp_rd || rep_slot;
      if (exp_rd) begin
        rep_slot = REP && (popped % width == width - 1);
        popped++;
      end else begin
        rep_slot = 0;
      end
      pend = pend_nx;
      if (exp_done) done_cyc = cyc;
      seen = exp_done || (ap_done === 1'b1);
      @(posedge ap_clk); #1;
      if (seen) break;
    end
    ap_start = 1'b0;
    exp_cyc = (P == 0) ? 1 : 1 + P + stalls + (REP ? rows : 0);
    checks++;
    if (!seen || done_cyc != exp_cyc || q.size() != 0) begin
      errors++;
      $display("FAIL done_cycle: got %0d (left %0d) want %0d",
               done_cyc, q.size(), exp_cyc);
    end
    if (exp_dc >= 0) begin
      checks++;
      if (done_cyc != exp_dc) begin
        errors++;
        $display("FAIL done_cycle_abs: got %0d want %0d", done_cyc, exp_dc);
      end
    end
    exp_nl = (P == 0) ? first : (first + rows) % NUM_LINES;
    checks++;
    if (next_line !== LSEL_W'(exp_nl)) begin
      errors++;
      $display("FAIL next_line: got %0d want %0d", next_line, exp_nl);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    ap_start = 1'b1;
    src_empty_n = 1'b1;
    src_dout = PIX_W'($urandom);
    num_rows = 4;
    row_width = 5;
    first_line = 0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 ||
        src_read !== 1'b0 || lb_we0 !== '0 || lb_ce0 !== '0 ||
        lb_address0 !== '0 || lb_d0 !== '0 || next_line !== '0) begin
      errors++;
      $display("FAIL reset: idle=%b done=%b rdy=%b rd=%b we=%b ce=%b a=%0d d=%h nl=%0d",
               ap_idle, ap_done, ap_ready, src_read, lb_we0, lb_ce0,
               lb_address0, lb_d0, next_line);
    end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic();
    run(4, 5, 0, 0, -1, 0, 1'b1, REP ? 25 : 21);
  endtask

  task automatic test_stall();
    run(4, 5, 0, 0, 7, 3, 1'b1, REP ? 28 : 24);
  endtask

  task automatic test_degenerate();
    run(0, 5, 1, 0, -1, 0, 1'b0, 1);
    @(posedge ap_clk); #1;
    run(3, 0, 2, 0, -1, 0, 1'b0, 1);
  endtask

  task automatic test_first_line();
    run(2, 2, 2, 0, -1, 0, 1'b0, REP ? 7 : 5);
  endtask

  task automatic test_reset_mid();
    ap_start = 1'b1;
    num_rows = 4;
    row_width = 5;
    first_line = 0;
    src_empty_n = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (8) begin
      src_dout = PIX_W'($urandom);
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (src_read !== 1'b0 || lb_we0 !== '0 || ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rd=%b we=%b idle=%b done=%b want 0 0 1 0",
               src_read, lb_we0, ap_idle, ap_done);
    end
    @(posedge ap_clk); #1;
    run(4, 5, 0, 0, -1, 0, 1'b0, REP ? 25 : 21);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run(int'($urandom_range(1, 4)), int'($urandom_range(1, 8)),
          int'($urandom_range(0, NUM_LINES - 1)), 30, -1, 0, 1'b0, -1);
      repeat ($urandom_range(0, 2)) @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    run(2, 3, 1, 0, -1, 0, 1'b0, -1);
    run(3, 2, int'(next_line), 20, -1, 0, 1'b0, -1);
    run(1, 4, int'(next_line), 0, -1, 0, 1'b0, -1);
  endtask

  initial begin
    ap_rst = 1'b1;
    ap_start = 1'b0;
    num_rows = '0;
    row_width = '0;
    first_line = '0;
    src_dout = '0;
    src_empty_n = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_degenerate();
    test_first_line();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
